// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide engine: operation codes,
// FSM state encoding and small operation-decode helpers.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;
    localparam logic [2:0] MD_MSUB  = 3'd6;
    localparam logic [2:0] MD_MSUBU = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV0 = 3'd1,
        ST_BUSY = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // Even op codes are the signed variants.
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    // DIV and DIVU share the pattern 01x.
    function automatic logic is_div(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide engine handshake and data bundle.
// master = EX stage, slave = muldiv_unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic                start_i;
    logic                annul_i;
    logic [2:0]          op_i;
    logic [XLEN-1:0]     opdata1_i;
    logic [XLEN-1:0]     opdata2_i;
    logic [2*XLEN-1:0]   hilo_i;
    logic [2*XLEN-1:0]   result_o;
    logic                ready_o;
    logic                busy_o;
    logic                div_zero_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement of a W-bit value; used for operand absolute
// values and for the final sign fix-up of products, quotients and remainders.
module muldiv_negate #(
    parameter int W = 64
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    // Pass through, or invert-and-increment when negation is requested.
    always_comb begin
        if (neg_i) begin
            val_o = ~val_i + {{(W-1){1'b0}}, 1'b1};
        end else begin
            val_o = val_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: one shift-add (MUL) or restoring
// subtract-shift (DIV) step per cycle on a shared 2*XLEN shift register.
// Optional feature macro: MULDIV_ACC_EN adds MADD/MADDU/MSUB/MSUBU through an
// extra ACC state; without it op codes 4-7 behave as MULT/MULTU.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  md
);

    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic [XLEN-1:0]     op2_q, op2_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   result_q, result_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                dz_q, dz_d;

    logic [2:0]          op_eff_s;
    logic                accept_s;
    logic                sgn_in_s;
    logic                zero_div_s;
    logic [XLEN-1:0]     abs1_s, abs2_s;
    logic                op_div_s;
    logic                last_step_s;
    logic                acc_mode_s;
    logic [XLEN:0]       add_a_s, add_b_s, sum_s;
    logic                ge_s;
    logic [2*XLEN-1:0]   step_s;
    logic                neg_res_s, neg_rem_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s;
    logic [2*XLEN-1:0]   fixed_s;
    logic [2*XLEN-1:0]   acc_sum_s;

`ifdef MULDIV_ACC_EN
    assign op_eff_s   = md.op_i;
    assign acc_mode_s = op_q[2];
    assign acc_sum_s  = op_q[1] ? (md.hilo_i - acc_q) : (md.hilo_i + acc_q);
`else
    logic unused_hilo_s;
    assign op_eff_s      = md.op_i[2] ? {2'b00, md.op_i[0]} : md.op_i;
    assign acc_mode_s    = 1'b0;
    assign acc_sum_s     = acc_q;
    assign unused_hilo_s = ^md.hilo_i;
`endif

    assign accept_s    = (state_q == ST_IDLE) && md.start_i && !md.annul_i;
    assign sgn_in_s    = is_signed(op_eff_s);
    assign zero_div_s  = is_div(op_eff_s) && (md.opdata2_i == {XLEN{1'b0}});
    assign op_div_s    = is_div(op_q);
    assign last_step_s = (cnt_q == CNT_W'(XLEN - 1));

    muldiv_negate #(.W(XLEN)) u_abs1 (
        .neg_i (sgn_in_s & md.opdata1_i[XLEN-1]),
        .val_i (md.opdata1_i),
        .val_o (abs1_s)
    );

    muldiv_negate #(.W(XLEN)) u_abs2 (
        .neg_i (sgn_in_s & md.opdata2_i[XLEN-1]),
        .val_i (md.opdata2_i),
        .val_o (abs2_s)
    );

    // Shared (XLEN+1)-bit adder: adds the multiplicand into HI for MUL,
    // subtracts the divisor from the shifted partial remainder for DIV.
    always_comb begin
        if (op_div_s) begin
            add_a_s = {1'b0, acc_q[2*XLEN-2:XLEN-1]};
        end else begin
            add_a_s = {1'b0, acc_q[2*XLEN-1:XLEN]};
        end
        add_b_s = {1'b0, op2_q};
        sum_s   = add_a_s + (add_b_s ^ {(XLEN+1){op_div_s}}) + {{XLEN{1'b0}}, op_div_s};
        // The bit shifted out of the remainder guarantees the subtraction fits.
        ge_s    = acc_q[2*XLEN-1] | ~sum_s[XLEN];
    end

    // One iteration: restoring divide step or shift-add multiply step.
    always_comb begin
        if (op_div_s) begin
            step_s = {(ge_s ? sum_s[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]),
                      acc_q[XLEN-2:0], ge_s};
        end else if (acc_q[0]) begin
            step_s = {sum_s, acc_q[XLEN-1:1]};
        end else begin
            step_s = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    assign neg_res_s = is_signed(op_q) & (s1_q ^ s2_q);
    assign neg_rem_s = is_signed(op_q) & s1_q;

    muldiv_negate #(.W(2*XLEN)) u_fix_prod (
        .neg_i (neg_res_s),
        .val_i (step_s),
        .val_o (prod_fix_s)
    );

    muldiv_negate #(.W(XLEN)) u_fix_quo (
        .neg_i (neg_res_s),
        .val_i (step_s[XLEN-1:0]),
        .val_o (quo_fix_s)
    );

    muldiv_negate #(.W(XLEN)) u_fix_rem (
        .neg_i (neg_rem_s),
        .val_i (step_s[2*XLEN-1:XLEN]),
        .val_o (rem_fix_s)
    );

    assign fixed_s = op_div_s ? {rem_fix_s, quo_fix_s} : prod_fix_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; annul always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = zero_div_s ? ST_DIV0 : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV0: begin
                state_d = md.annul_i ? ST_IDLE : ST_DONE;
            end
            ST_BUSY: begin
                if (md.annul_i) begin
                    state_d = ST_IDLE;
                end else if (last_step_s) begin
                    state_d = acc_mode_s ? ST_ACC : ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_ACC: begin
                state_d = md.annul_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (!md.start_i || md.annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output and datapath next-value logic.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        op2_d    = op2_q;
        acc_d    = acc_q;
        result_d = result_q;
        dz_d     = dz_q;
        busy_d   = 1'b0;
        ready_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d  = op_eff_s;
                    s1_d  = sgn_in_s & md.opdata1_i[XLEN-1];
                    s2_d  = sgn_in_s & md.opdata2_i[XLEN-1];
                    op2_d = abs2_s;
                    acc_d = {{XLEN{1'b0}}, abs1_s};
                    cnt_d = {CNT_W{1'b0}};
                    dz_d  = 1'b0;
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_DIV0: begin
                acc_d  = {(2*XLEN){1'b0}};
                dz_d   = ~md.annul_i;
                busy_d = ~md.annul_i;
            end
            ST_BUSY: begin
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                acc_d  = last_step_s ? fixed_s : step_s;
                busy_d = ~md.annul_i;
            end
            ST_ACC: begin
                acc_d  = acc_sum_s;
                busy_d = ~md.annul_i;
            end
            ST_DONE: begin
                if (md.start_i && !md.annul_i) begin
                    ready_d  = 1'b1;
                    result_d = acc_q;
                end else begin
                    ready_d  = 1'b0;
                end
            end
            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 3'd0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            op2_q    <= {XLEN{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            result_q <= {(2*XLEN){1'b0}};
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            op2_q    <= op2_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            dz_q     <= dz_d;
        end
    end

    assign md.result_o   = result_q;
    assign md.ready_o    = ready_q;
    assign md.busy_o     = busy_q;
    assign md.div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) md_if ();

    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md_if)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] last_res = 64'd0;
    logic [63:0] got;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] eff_op(input logic [2:0] op);
`ifdef MULDIV_ACC_EN
        return op;
`else
        return op[2] ? {2'b00, op[0]} : op;
`endif
    endfunction

    // Reference result from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
        logic [2:0]  e;
        longint      sa, sb, q, r;
        logic [63:0] prod, uq, ur;
        e  = eff_op(op);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (e[0]) prod = {32'd0, a} * {32'd0, b};
        else      prod = 64'(sa * sb);
        case (e)
            3'd0, 3'd1: return prod;
            3'd2: begin
                if (b == 32'd0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return 64'd0;
                uq = {32'd0, a} / {32'd0, b};
                ur = {32'd0, a} % {32'd0, b};
                return {ur[31:0], uq[31:0]};
            end
            default: return e[1] ? (hilo - prod) : (hilo + prod);
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, hold start through ready (plus hold extra cycles), then release.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hilo, input int hold, output logic [63:0] res);
        int          cyc, busy_n, exp_lat, exp_busy;
        logic        seen, div0;
        logic [2:0]  e;
        logic [63:0] exp;
        e        = eff_op(op);
        div0     = (e == 3'd2 || e == 3'd3) && (b == 32'd0);
        exp      = ref_result(op, a, b, hilo);
        exp_lat  = div0 ? 2 : (e[2] ? XLEN + 2 : XLEN + 1);
        exp_busy = exp_lat - 1;
        md_if.op_i = op; md_if.opdata1_i = a; md_if.opdata2_i = b;
        md_if.hilo_i = hilo; md_if.start_i = 1'b1; md_if.annul_i = 1'b0;
        @(posedge clk); #1;
        busy_n = int'(md_if.busy_o);
        cyc = 0; seen = 1'b0;
        md_if.opdata1_i = $urandom;
        md_if.opdata2_i = $urandom;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (md_if.ready_o) seen = 1'b1;
            else busy_n += int'(md_if.busy_o);
        end
        res = md_if.result_o;
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("busy_cycles", 64'(busy_n), 64'(exp_busy));
        check_eq("result", md_if.result_o, exp);
        check_eq("div_zero", 64'(md_if.div_zero_o), 64'(div0));
        check_eq("busy_at_ready", 64'(md_if.busy_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_ready", 64'(md_if.ready_o), 64'd1);
            check_eq("hold_busy", 64'(md_if.busy_o), 64'd0);
            check_eq("hold_result", md_if.result_o, exp);
        end
        md_if.start_i = 1'b0;
        @(posedge clk); #1;
        check_eq("release_ready", 64'(md_if.ready_o), 64'd0);
        check_eq("release_busy", 64'(md_if.busy_o), 64'd0);
        last_res = exp;
    endtask

    // Start an op and annul it k cycles after accept.
    task automatic annul_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        md_if.op_i = op; md_if.opdata1_i = a; md_if.opdata2_i = b;
        md_if.start_i = 1'b1; md_if.annul_i = 1'b0;
        @(posedge clk); #1;
        repeat (k) begin
            @(posedge clk); #1;
        end
        md_if.annul_i = 1'b1; md_if.start_i = 1'b0;
        @(posedge clk); #1;
        md_if.annul_i = 1'b0;
        check_eq("annul_busy", 64'(md_if.busy_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("annul_no_ready", 64'(md_if.ready_o), 64'd0);
            check_eq("annul_keep", md_if.result_o, last_res);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        md_if.start_i = 1'b0; md_if.annul_i = 1'b0; md_if.op_i = 3'd0;
        md_if.opdata1_i = 32'd0; md_if.opdata2_i = 32'd0; md_if.hilo_i = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_result", md_if.result_o, 64'd0);
        check_eq("rst_ready", 64'(md_if.ready_o), 64'd0);
        check_eq("rst_busy", 64'(md_if.busy_o), 64'd0);
        check_eq("rst_dz", 64'(md_if.div_zero_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 0, got);
        check_eq("mult_m3x5", got, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'd3, 32'd100, 32'd7, 64'd0, 1, got);
        check_eq("divu_100_7", got, 64'h0000_0002_0000_000E);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 0, got);
        check_eq("div_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'd5, 32'd0, 64'd0, 0, got);
        check_eq("div_by_zero", got, 64'd0);
        run_op(3'd1, 32'd2, 32'd3, 64'd0, 0, got);
        check_eq("multu_2x3", got, 64'd6);

        annul_op(3'd2, 32'd1000, 32'd3, 10);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 64'd0, 0, got);
        check_eq("multu_ffx2", got, 64'h0000_0001_FFFF_FFFE);

        // start and annul together in IDLE: nothing is accepted
        md_if.op_i = 3'd0; md_if.start_i = 1'b1; md_if.annul_i = 1'b1;
        @(posedge clk); #1;
        md_if.start_i = 1'b0; md_if.annul_i = 1'b0;
        @(posedge clk); #1;
        check_eq("start_annul_busy", 64'(md_if.busy_o), 64'd0);
        check_eq("start_annul_result", md_if.result_o, last_res);

        // start held high in DONE must not relaunch
        run_op(3'd0, 32'd7, 32'd9, 64'd0, 3, got);

        // asynchronous reset in the middle of BUSY
        md_if.op_i = 3'd0; md_if.opdata1_i = 32'd11; md_if.opdata2_i = 32'd13;
        md_if.start_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 64'(md_if.busy_o), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_result", md_if.result_o, 64'd0);
        check_eq("arst_busy", 64'(md_if.busy_o), 64'd0);
        check_eq("arst_ready", 64'(md_if.ready_o), 64'd0);
        md_if.start_i = 1'b0;
        #1;
        rst = 1'b0;
        last_res = 64'd0;
        @(posedge clk); #1;

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 0, got);
        check_eq("div_overflow", got, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 64'd0, 0, got);
        check_eq("div_7_m2", got, 64'h0000_0001_FFFF_FFFD);

`ifdef MULDIV_ACC_EN
        run_op(3'd4, 32'd2, 32'd3, 64'd1, 0, got);
        check_eq("madd_2x3_p1", got, 64'd7);
        run_op(3'd7, 32'd1, 32'd1, 64'd0, 0, got);
        check_eq("msubu_1x1", got, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        run_op(3'd4, 32'd2, 32'd3, 64'd1, 0, got);
        check_eq("op4_as_mult", got, 64'd6);
        run_op(3'd7, 32'hFFFF_FFFF, 32'd2, 64'd5, 0, got);
        check_eq("op7_as_multu", got, 64'h0000_0001_FFFF_FFFE);
`endif

        for (int n = 0; n < 30; n++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(),
                   {$urandom, $urandom}, $urandom_range(0, 2), got);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
